// File: rtl/prf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prf_wr_arbiter
// Description : Shares the banked PRF write ports among all writeback
//               requesters. Each requester feeds a small in-order FIFO. One
//               round-robin arbiter per bank picks at most one FIFO head per
//               cycle. The winning write is registered onto the bank port and
//               onto the wakeup broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
module prf_wr_arbiter #(
   parameter int PRF_WR_COUNT             = 8,
   parameter int PRF_BANK_COUNT           = 4,
   parameter int PR_COUNT                 = 128,
   parameter int PRF_WR_INPUT_BUFFER_SIZE = 2,
   parameter int XLEN                     = 64,
   localparam int c_pr_w                  = $clog2(PR_COUNT),
   localparam int c_bank_w                = $clog2(PRF_BANK_COUNT),
   localparam int c_upr_w                 = c_pr_w - c_bank_w,
   localparam int c_rq_w                  = $clog2(PRF_WR_COUNT)
) (
   input  logic                                      CLK,
   input  logic                                      nRST,
   input  logic [PRF_WR_COUNT-1:0]                   wr_req_valid_by_rq,
   input  logic [PRF_WR_COUNT-1:0][c_pr_w-1:0]       wr_req_PR_by_rq,
   input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]         wr_req_data_by_rq,
   output logic [PRF_WR_COUNT-1:0]                   wr_req_ready_by_rq,
   output logic [PRF_BANK_COUNT-1:0]                 wr_valid_by_bank,
   output logic [PRF_BANK_COUNT-1:0][c_upr_w-1:0]    wr_upper_PR_by_bank,
   output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]       wr_data_by_bank,
   output logic [PRF_BANK_COUNT-1:0][c_rq_w-1:0]     wr_rq_by_bank,
   output logic [PRF_BANK_COUNT-1:0][c_pr_w-1:0]     wb_PR_by_bank
);

   localparam int c_depth = PRF_WR_INPUT_BUFFER_SIZE;
   localparam int c_cnt_w = $clog2(c_depth + 1);

   // FIFO storage: slot 0 is always the head, entries shift down on dequeue
   logic [c_pr_w-1:0]                          r_fifo_pr   [PRF_WR_COUNT][c_depth];
   logic [XLEN-1:0]                            r_fifo_data [PRF_WR_COUNT][c_depth];
   logic [PRF_WR_COUNT-1:0][c_cnt_w-1:0]       r_cnt;
   logic [PRF_BANK_COUNT-1:0][c_rq_w-1:0]      r_ptr;

   logic [PRF_WR_COUNT-1:0]                    w_enq;
   logic [PRF_WR_COUNT-1:0]                    w_deq;
   logic [PRF_WR_COUNT-1:0][c_cnt_w-1:0]       w_wr_pos;
   logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_cand;
   logic [PRF_BANK_COUNT-1:0]                  w_gnt;
   logic [PRF_BANK_COUNT-1:0][c_rq_w-1:0]      w_gnt_rq;

   // Per-requester handshake and per-bank candidate decode from the FIFO head.
   // Ready looks only at the registered count, never at a same-cycle dequeue.
   for (genvar r = 0; r < PRF_WR_COUNT; r++) begin : g_rq
      assign wr_req_ready_by_rq[r] = (r_cnt[r] < c_cnt_w'(c_depth));
      assign w_enq[r]              = wr_req_valid_by_rq[r] & wr_req_ready_by_rq[r];
      // Slot the incoming entry lands in after any shift from a dequeue
      assign w_wr_pos[r]           = r_cnt[r] - c_cnt_w'(w_deq[r]);
      for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_cand
         assign w_cand[b][r] = (r_cnt[r] != '0) &&
                               (r_fifo_pr[r][0][c_bank_w-1:0] == c_bank_w'(b));
      end
   end

   // Round-robin pick per bank: first candidate at or after the pointer, wrapping
   always_comb begin
      int idx;
      idx      = 0;
      w_gnt    = '0;
      w_gnt_rq = '0;
      w_deq    = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         for (int i = 0; i < PRF_WR_COUNT; i++) begin
            idx = (int'(r_ptr[b]) + i) % PRF_WR_COUNT;
            if (!w_gnt[b] && w_cand[b][idx]) begin
               w_gnt[b]    = 1'b1;
               w_gnt_rq[b] = c_rq_w'(idx);
            end
         end
         // A requester only offers its head to one bank, so no double dequeue
         if (w_gnt[b]) begin
            w_deq[w_gnt_rq[b]] = 1'b1;
         end
      end
   end

   // FIFO occupancy; reset empties every FIFO and so drops buffered writes
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cnt <= '0;
      end else begin
         for (int r = 0; r < PRF_WR_COUNT; r++) begin
            r_cnt[r] <= r_cnt[r] + c_cnt_w'(w_enq[r]) - c_cnt_w'(w_deq[r]);
         end
      end
   end

   // FIFO payload: shift toward the head on dequeue, write the new entry behind
   always_ff @(posedge CLK) begin
      for (int r = 0; r < PRF_WR_COUNT; r++) begin
         for (int k = 0; k < c_depth; k++) begin
            if (w_enq[r] && (w_wr_pos[r] == c_cnt_w'(k))) begin
               r_fifo_pr[r][k]   <= wr_req_PR_by_rq[r];
               r_fifo_data[r][k] <= wr_req_data_by_rq[r];
            end else if (w_deq[r] && (k < c_depth - 1)) begin
               r_fifo_pr[r][k]   <= r_fifo_pr[r][(k + 1 < c_depth) ? k + 1 : k];
               r_fifo_data[r][k] <= r_fifo_data[r][(k + 1 < c_depth) ? k + 1 : k];
            end
         end
      end
   end

   // Bank write port and wakeup broadcast, one cycle after the grant; payload
   // fields hold when idle, only valid is meaningful then
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ptr               <= '0;
         wr_valid_by_bank    <= '0;
         wr_upper_PR_by_bank <= '0;
         wr_data_by_bank     <= '0;
         wr_rq_by_bank       <= '0;
         wb_PR_by_bank       <= '0;
      end else begin
         for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            wr_valid_by_bank[b] <= w_gnt[b];
            if (w_gnt[b]) begin
               r_ptr[b]               <= c_rq_w'((int'(w_gnt_rq[b]) + 1) % PRF_WR_COUNT);
               wr_upper_PR_by_bank[b] <= r_fifo_pr[w_gnt_rq[b]][0][c_pr_w-1:c_bank_w];
               wr_data_by_bank[b]     <= r_fifo_data[w_gnt_rq[b]][0];
               wr_rq_by_bank[b]       <= w_gnt_rq[b];
               wb_PR_by_bank[b]       <= r_fifo_pr[w_gnt_rq[b]][0];
            end
         end
      end
   end

endmodule
`default_nettype wire
